// File: rtl/layer_input_feeder.sv
// Producer side of the layer-node input interface: slides a 5-sample window over the
// serial signed ECG stream and flags when the node bank's outputs reflect each window.
module layer_input_feeder #(
    parameter int STRIDE   = 1,
    parameter int NODE_LAT = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic signed [7:0]  sample_in,
    input  logic               sample_valid,
    output logic               sample_ready,
    output logic signed [7:0]  A0x,
    output logic signed [7:0]  A1x,
    output logic signed [7:0]  A2x,
    output logic signed [7:0]  A3x,
    output logic signed [7:0]  A4x,
    output logic               vec_valid,
    output logic               node_valid,
    output logic [15:0]        vec_cnt
);

    typedef enum logic [1:0] {
        FILL,
        PRESENT,
        STRIDE_WAIT
    } state_t;

    localparam logic [2:0] FILL_LAST   = 3'd4;
    localparam logic [2:0] STRIDE_LAST = 3'(STRIDE - 1);

    state_t               state;
    state_t               next_state;
    logic signed [7:0]    win [5];
    logic [2:0]           fill_cnt;
    logic [2:0]           new_cnt;
    logic                 accept;
    logic                 complete;
    logic [NODE_LAT-1:0]  node_pipe;

    // Handshake and window-completion decode; flush forces a fresh fill from any state.
    always_comb begin
        next_state   = state;
        complete     = 1'b0;
        sample_ready = !flush && (state != PRESENT);
        accept       = sample_valid && sample_ready;
        case (state)
            FILL: begin
                if (accept && fill_cnt == FILL_LAST) begin
                    complete   = 1'b1;
                    next_state = PRESENT;
                end
            end
            PRESENT: begin
                next_state = STRIDE_WAIT;
            end
            STRIDE_WAIT: begin
                if (accept && new_cnt == STRIDE_LAST) begin
                    complete   = 1'b1;
                    next_state = PRESENT;
                end
            end
            default: begin
                next_state = FILL;
            end
        endcase
        if (flush) begin
            next_state = FILL;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FILL;
        end else begin
            state <= next_state;
        end
    end

    // Window shift register and fill/stride counters; flush discards only the window side.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            for (int i = 0; i < 5; i++) begin
                win[i] <= '0;
            end
            fill_cnt <= '0;
            new_cnt  <= '0;
        end else begin
            if (accept) begin
                for (int i = 0; i < 4; i++) begin
                    win[i] <= win[i+1];
                end
                win[4] <= sample_in;
            end
            if (state == FILL && accept) begin
                fill_cnt <= fill_cnt + 3'd1;
            end
            if (state == PRESENT) begin
                new_cnt <= '0;
            end else if (state == STRIDE_WAIT && accept) begin
                new_cnt <= new_cnt + 3'd1;
            end
        end
    end

    // Presented window, its pulse, and the node-latency delay line survive a flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            A0x       <= '0;
            A1x       <= '0;
            A2x       <= '0;
            A3x       <= '0;
            A4x       <= '0;
            vec_valid <= 1'b0;
            vec_cnt   <= '0;
            node_pipe <= '0;
        end else begin
            vec_valid <= complete;
            node_pipe <= (node_pipe << 1) | NODE_LAT'(vec_valid);
            if (complete) begin
                A0x     <= win[1];
                A1x     <= win[2];
                A2x     <= win[3];
                A3x     <= win[4];
                A4x     <= sample_in;
                vec_cnt <= vec_cnt + 16'd1;
            end
        end
    end

    assign node_valid = node_pipe[NODE_LAT-1];

endmodule

// File: tb/tb_layer_input_feeder.sv
// Randomized scoreboard bench for layer_input_feeder: a sample-history model predicts each
// window, its count and the node_valid pulse time; a negedge monitor checks them.
module tb_layer_input_feeder;

    localparam int STRIDE   = 2;
    localparam int NODE_LAT = 3;
    localparam int PERIOD   = 10;

    typedef struct {
        longint      due;
        bit          isReset;
        logic [39:0] a;
        logic [15:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic [7:0]  sample_in = '0;
    logic        sample_valid = 1'b0;
    logic        sample_ready;
    logic [7:0]  A0x, A1x, A2x, A3x, A4x;
    logic        vec_valid;
    logic        node_valid;
    logic [15:0] vec_cnt;

    int          vectors = 0;
    int          errors = 0;

    exp_t        winQ[$];
    longint      nodeQ[$];
    logic [7:0]  hist[$];
    int          accCnt = 0;
    bit          present = 0;
    logic [15:0] vcnt = '0;

    layer_input_feeder #(.STRIDE(STRIDE), .NODE_LAT(NODE_LAT)) dut (
        .clk(clk), .reset(reset), .flush(flush), .sample_in(sample_in),
        .sample_valid(sample_valid), .sample_ready(sample_ready),
        .A0x(A0x), .A1x(A1x), .A2x(A2x), .A3x(A3x), .A4x(A4x),
        .vec_valid(vec_valid), .node_valid(node_valid), .vec_cnt(vec_cnt)
    );

    always #(PERIOD/2) clk = ~clk;

    task automatic checkOutput(input string name, input logic [39:0] act, input logic [39:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // One cycle of stimulus; the model predicts ready, acceptance and any completed window.
    task automatic applyStimulus(input bit v, input logic [7:0] d, input bit f, input bit r,
                                 output bit acc);
        longint tNow;
        bit     wasPresent;
        exp_t   e;
        @(negedge clk);
        tNow = $time;
        sample_valid = v;
        sample_in    = d;
        flush        = f;
        reset        = r;
        #1;
        checkOutput("sample_ready", {39'd0, sample_ready}, {39'd0, (!f && !present)});
        acc = 0;
        if (r) begin
            hist.delete();
            accCnt  = 0;
            present = 0;
            vcnt    = '0;
            winQ.delete();
            nodeQ.delete();
            e.due = tNow + PERIOD; e.isReset = 1; e.a = '0; e.cnt = '0;
            winQ.push_back(e);
        end else if (f) begin
            hist.delete();
            accCnt  = 0;
            present = 0;
        end else begin
            wasPresent = present;
            present    = 0;
            if (v && !wasPresent) begin
                acc = 1;
                hist.push_back(d);
                if (hist.size() > 5) void'(hist.pop_front());
                accCnt++;
                if (accCnt >= 5 && (accCnt - 5) % STRIDE == 0) begin
                    vcnt++;
                    e.due = tNow + PERIOD; e.isReset = 0; e.cnt = vcnt;
                    e.a = {hist[0], hist[1], hist[2], hist[3], hist[4]};
                    winQ.push_back(e);
                    nodeQ.push_back(tNow + PERIOD * (1 + NODE_LAT));
                    present = 1;
                end
            end
        end
    endtask

    task automatic feed(input logic [7:0] d);
        bit acc;
        int guard;
        guard = 0;
        do begin
            applyStimulus(1, d, 0, 0, acc);
            guard++;
        end while (!acc && guard < 4);
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) applyStimulus(0, 8'h00, 0, 0, acc);
    endtask

    // Monitor: pops due windows on vec_valid, checks held outputs and node_valid timing.
    initial begin : monitor
        bit          armed;
        bit          expV;
        bit          expN;
        longint      tm;
        exp_t        e;
        logic [39:0] lastA;
        logic [15:0] lastCnt;
        armed = 0;
        lastA = '0;
        lastCnt = '0;
        forever begin
            @(negedge clk);
            tm   = $time;
            expV = (winQ.size() > 0) && (winQ[0].due == tm);
            if (expV) begin
                e = winQ.pop_front();
                lastA   = e.a;
                lastCnt = e.cnt;
                armed   = 1;
                checkOutput(e.isReset ? "vec_valid_after_reset" : "vec_valid_pulse",
                            {39'd0, vec_valid}, {39'd0, !e.isReset});
            end else if (armed) begin
                checkOutput("vec_valid_idle", {39'd0, vec_valid}, 40'd0);
            end
            if (armed) begin
                checkOutput("window_A0x_A4x", {A0x, A1x, A2x, A3x, A4x}, lastA);
                checkOutput("vec_cnt", {24'd0, vec_cnt}, {24'd0, lastCnt});
                expN = (nodeQ.size() > 0) && (nodeQ[0] == tm);
                if (expN) void'(nodeQ.pop_front());
                checkOutput("node_valid", {39'd0, node_valid}, {39'd0, expN});
            end
        end
    end

    initial begin : stimulus
        bit acc;
        applyStimulus(0, 8'h00, 0, 1, acc);
        applyStimulus(1, 8'h33, 0, 1, acc);
        for (int i = 1; i <= 5; i++) feed(8'(i));
        feed(8'd6);
        feed(8'd7);
        idle(6);
        applyStimulus(1, 8'd9, 1, 0, acc);
        for (int i = 10; i <= 16; i++) feed(8'(i));
        idle(2);
        applyStimulus(0, 8'h00, 0, 1, acc);
        for (int i = 1; i <= 3; i++) feed(8'(i));
        applyStimulus(0, 8'h00, 0, 1, acc);
        for (int i = 20; i <= 24; i++) feed(8'(i));
        applyStimulus(0, 8'h00, 0, 1, acc);
        idle(5);
        feed(8'h80);
        feed(8'h7F);
        feed(8'hFF);
        feed(8'h00);
        feed(8'h01);
        idle(5);
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom_range(0, 3) != 0), 8'($urandom),
                          ($urandom_range(0, 39) == 0), ($urandom_range(0, 149) == 0), acc);
        end
        idle(NODE_LAT + 6);
        checkOutput("pending_windows", 40'(winQ.size()), 40'd0);
        checkOutput("pending_node_valid", 40'(nodeQ.size()), 40'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
